// File: rtl/rotate_req_stage.sv
// Flow-controlled rotate front end: requests queue in a small FIFO, the shift is reduced to a
// left-rotate count, and the barrel_shifter result is registered. Option macro: ROT_RANGE_CHECK_EN.

module barrel_shifter #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = ((DATA_WIDTH & (DATA_WIDTH - 1)) == 0) ?
                              $clog2(DATA_WIDTH) : $clog2(DATA_WIDTH) + 1
) (
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [SHIFT_WIDTH-1:0] shift_val_in,
  output logic [DATA_WIDTH-1:0]  data_out
);

  logic [DATA_WIDTH-1:0] w_stage [SHIFT_WIDTH+1];

  assign w_stage[0] = data_in;

  // Stage gi rotates left by 2**gi mod DATA_WIDTH, so the stages compose to shift mod DATA_WIDTH.
  genvar gi;
  generate
    for (gi = 0; gi < SHIFT_WIDTH; gi++) begin : g_stage
      localparam int AMT = (2 ** gi) % DATA_WIDTH;
      if (AMT == 0) begin : g_nop
        assign w_stage[gi+1] = w_stage[gi];
      end else begin : g_rot
        assign w_stage[gi+1] = shift_val_in[gi] ?
          {w_stage[gi][DATA_WIDTH-1-AMT:0], w_stage[gi][DATA_WIDTH-1:DATA_WIDTH-AMT]} :
          w_stage[gi];
      end
    end
  endgenerate

  assign data_out = w_stage[SHIFT_WIDTH];

endmodule

module rotate_req_stage #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = ((DATA_WIDTH & (DATA_WIDTH - 1)) == 0) ?
                              $clog2(DATA_WIDTH) : $clog2(DATA_WIDTH) + 1,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  input  logic                   in_dir,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [31:0]   WIDTH_U    = 32'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0]  r_data_mem  [DEPTH];
  logic [SHIFT_WIDTH-1:0] r_shift_mem [DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_out_valid;
  logic [DATA_WIDTH-1:0]  r_out_data;

  logic [31:0]            w_shift_ext;
  logic [SHIFT_WIDTH-1:0] w_s_mod;
  logic [SHIFT_WIDTH-1:0] w_eff_shift;
  logic                   w_push;
  logic                   w_pop;
  logic [DATA_WIDTH-1:0]  w_head_data;
  logic [SHIFT_WIDTH-1:0] w_head_shift;
  logic [DATA_WIDTH-1:0]  w_rot_data;

  // No bypass when full: a same-cycle pop does not open the input.
  assign in_ready = !rst && (r_count != FULL_COUNT);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_count != '0) && (!r_out_valid || out_ready);

  // A right rotate by s is a left rotate by (W - s) mod W.
  assign w_shift_ext = 32'(in_shift);
  assign w_s_mod     = SHIFT_WIDTH'(w_shift_ext % WIDTH_U);
  assign w_eff_shift = (!in_dir || (w_s_mod == '0)) ? w_s_mod :
                       SHIFT_WIDTH'(WIDTH_U - 32'(w_s_mod));

  assign w_head_data  = r_data_mem[r_rd_ptr];
  assign w_head_shift = r_shift_mem[r_rd_ptr];

  barrel_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_rotator (
    .data_in      (w_head_data),
    .shift_val_in (w_head_shift),
    .data_out     (w_rot_data)
  );

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr]  <= in_data;
      r_shift_mem[r_wr_ptr] <= w_eff_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rot_data;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef ROT_RANGE_CHECK_EN
  logic r_err_mem [DEPTH];
  logic r_out_err;
  logic w_err;

  assign w_err = (w_shift_ext >= WIDTH_U);

  always_ff @(posedge clk) begin
    if (w_push) r_err_mem[r_wr_ptr] <= w_err;
  end

  // The flag follows out_valid so it is never left asserted on an idle output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_err <= 1'b0;
    end else if (w_pop) begin
      r_out_err <= r_err_mem[r_rd_ptr];
    end else if (out_ready) begin
      r_out_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(r_out_err && !r_out_valid));
  end

  assign out_err = r_out_err;
`else
  assign out_err = 1'b0;
`endif

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_rotate_req_stage.sv
// Bench for rotate_req_stage: an 8-bit instance for flow control and a 6-bit instance for
// shift reduction, both checked against a bit-level rotate model.
module tb_rotate_req_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, in_dir, out_valid, out_ready, out_err;
  logic [7:0] in_data, out_data;
  logic [2:0] in_shift, fifo_count;

  logic       x_in_valid, x_in_ready, x_in_dir, x_out_valid, x_out_ready, x_out_err;
  logic [5:0] x_in_data, x_out_data;
  logic [2:0] x_in_shift, x_fifo_count;

  int total = 0;
  int bad   = 0;

`ifdef ROT_RANGE_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  rotate_req_stage #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shift(in_shift), .in_dir(in_dir), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .fifo_count(fifo_count)
  );

  rotate_req_stage #(.DATA_WIDTH(6), .SHIFT_WIDTH(3), .DEPTH(4)) dut6 (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready), .in_data(x_in_data),
    .in_shift(x_in_shift), .in_dir(x_in_dir), .out_valid(x_out_valid), .out_ready(x_out_ready),
    .out_data(x_out_data), .out_err(x_out_err), .fifo_count(x_fifo_count)
  );

  // Bit i of the word moves to (i + s) mod w on a left rotate; right is the inverse.
  function automatic logic [7:0] rot_ref(input logic [7:0] d, input int s, input logic right, input int w);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (right) r[i] = d[(i + s) % w];
      else       r[(i + s) % w] = d[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_shift = '0; in_dir = 1'b0;
    x_in_valid = 1'b0; x_out_ready = 1'b0; x_in_data = '0; x_in_shift = '0; x_in_dir = 1'b0;
    tick();
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    total++; if (x_out_valid !== 1'b0 || x_fifo_count !== 3'd0) begin
      bad++; $display("FAIL reset_dut6: got valid=%b count=%0d want 0/0", x_out_valid, x_fifo_count);
    end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_rotate_left();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h99; in_shift = 3'd3; in_dir = 1'b0;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL left_early: got valid=%b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'hCC) begin
      bad++; $display("FAIL left_result: got valid=%b data=%h want 1/cc", out_valid, out_data);
    end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL left_err: got %b want 0", out_err); end
    $display("xfer left data=%h err=%b", out_data, out_err);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL left_drain: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_rotate_right();
    logic [7:0] dv [2];
    logic [2:0] sv [2];
    logic [7:0] ev [2];
    dv = '{8'h99, 8'hA5}; sv = '{3'd3, 3'd0}; ev = '{8'h33, 8'hA5};
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = dv[k]; in_shift = sv[k]; in_dir = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== ev[k]) begin
        bad++; $display("FAIL right_%0d: got valid=%b data=%h want 1/%h", k, out_valid, out_data, ev[k]);
      end
      $display("xfer right data=%h err=%b", out_data, out_err);
      tick();
    end
  endtask

  task automatic test_reduction();
    logic [6:0] q[$];
    logic [6:0] e;
    logic [7:0] r;
    logic       ee;
    int sent = 0;
    int got = 0;
    bit acc;
    x_out_ready = 1'b1; x_in_valid = 1'b1; x_in_data = 6'b100001; x_in_shift = 3'd7; x_in_dir = 1'b0;
    for (int cyc = 0; cyc < 100 && got < 14; cyc++) begin
      if (x_out_valid === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL red_extra: got data=%h with nothing pending", x_out_data);
        end else begin
          e = q.pop_front();
          if ({x_out_err, x_out_data} !== e) begin
            bad++; $display("FAIL red_result_%0d: got err=%b data=%b want err=%b data=%b",
                            got, x_out_err, x_out_data, e[6], e[5:0]);
          end
        end
        $display("xfer rot6 data=%b err=%b", x_out_data, x_out_err);
        got++;
      end
      acc = x_in_valid && x_in_ready;
      if (acc) begin
        r  = rot_ref({2'b00, x_in_data}, int'(x_in_shift), x_in_dir, 6);
        ee = ERR_EN && (x_in_shift >= 3'd6);
        q.push_back({ee, r[5:0]});
      end
      tick();
      if (acc) begin
        sent++;
        if (sent == 1) begin
          x_in_data = 6'b100001; x_in_shift = 3'd6; x_in_dir = 1'b1;
        end else if (sent < 14) begin
          x_in_data = 6'($urandom); x_in_shift = 3'($urandom); x_in_dir = 1'($urandom);
        end else begin
          x_in_valid = 1'b0;
        end
      end
    end
    total++; if (got != 14) begin bad++; $display("FAIL red_count: got %0d results want 14", got); end
  endtask

  task automatic test_backpressure();
    int i = 1;
    bit rdy;
    out_ready = 1'b0; in_valid = 1'b1; in_dir = 1'b0; in_shift = 3'd0; in_data = 8'h01;
    for (int cyc = 0; cyc < 40 && i <= 5; cyc++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin i++; in_data = 8'(i); end
    end
    in_valid = 1'b0;
    total++; if (i != 6) begin bad++; $display("FAIL bp_accepts: got %0d want 5", i - 1); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL bp_count: got %0d want 4", fifo_count); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      bad++; $display("FAIL bp_head: got valid=%b data=%h want 1/01", out_valid, out_data);
    end
    tick();
    tick();
    total++; if (out_data !== 8'h01 || fifo_count !== 3'd4 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_hold: got data=%h count=%0d ready=%b want 01/4/0", out_data, fifo_count, in_ready);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      total++; if (out_valid !== 1'b1 || out_data !== 8'(k)) begin
        bad++; $display("FAIL bp_order_%0d: got valid=%b data=%h want 1/%h", k, out_valid, out_data, 8'(k));
      end
      if (k == 2) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_return: got %b want 1", in_ready); end
      end
      $display("xfer bp data=%h", out_data);
      tick();
    end
    total++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      bad++; $display("FAIL bp_empty: got valid=%b count=%0d want 0/0", out_valid, fifo_count);
    end
  endtask

  task automatic test_streaming();
    logic [8:0] q[$];
    logic [8:0] e;
    logic       ee;
    int sent = 0;
    int got = 0;
    bit acc;
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 8'($urandom); in_shift = 3'($urandom); in_dir = 1'($urandom);
    for (int cyc = 0; cyc < 100 && got < 16; cyc++) begin
      if (got > 0) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_bubble: got valid=%b want 1 after %0d", out_valid, got); end
      end
      total++; if (!(fifo_count <= 3'd1)) begin bad++; $display("FAIL stream_count: got %0d want <=1", fifo_count); end
      if (out_valid === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL stream_extra: got data=%h with nothing pending", out_data);
        end else begin
          e = q.pop_front();
          if ({out_err, out_data} !== e) begin
            bad++; $display("FAIL stream_result_%0d: got err=%b data=%h want err=%b data=%h",
                            got, out_err, out_data, e[8], e[7:0]);
          end
        end
        $display("xfer stream data=%h err=%b", out_data, out_err);
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        ee = ERR_EN && (int'(in_shift) >= 8);
        q.push_back({ee, rot_ref(in_data, int'(in_shift), in_dir, 8)});
      end
      tick();
      if (acc) begin
        sent++;
        if (sent < 16) begin
          in_data = 8'($urandom); in_shift = 3'($urandom); in_dir = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    total++; if (got != 16) begin bad++; $display("FAIL stream_total: got %0d results want 16", got); end
  endtask

  task automatic test_reset_mid();
    int i = 0;
    bit rdy;
    out_ready = 1'b0; in_valid = 1'b1; in_dir = 1'b0; in_shift = 3'd2; in_data = 8'h11;
    for (int cyc = 0; cyc < 40 && i < 4; cyc++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin i++; in_data = 8'h11 + 8'(i); end
    end
    in_valid = 1'b0;
    total++; if (fifo_count !== 3'd3 || out_valid !== 1'b1) begin
      bad++; $display("FAIL mid_fill: got count=%0d valid=%b want 3/1", fifo_count, out_valid);
    end
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %b want 0", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || fifo_count !== 3'd0 || out_data !== 8'h00) begin
      bad++; $display("FAIL mid_clear: got valid=%b count=%0d data=%h want 0/0/00", out_valid, fifo_count, out_data);
    end
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale_%0d: got valid=%b data=%h want 0", c, out_valid, out_data); end
    end
    in_valid = 1'b1; in_data = 8'h80; in_shift = 3'd1; in_dir = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      bad++; $display("FAIL mid_after: got valid=%b data=%h want 1/01", out_valid, out_data);
    end
    $display("xfer post_reset data=%h", out_data);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_tail: got valid=%b want 0", out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_reduction();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotate_req_stage.md
Name: rotate_req_stage

Overview:
- Registered, flow-controlled front end for the combinational barrel_shifter rotator.
- Accepts rotate requests (data, shift amount, direction) on a valid/ready stream and buffers them in a small FIFO.
- Reduces each shift amount to a legal left-rotate count modulo DATA_WIDTH, drives the rotator from the FIFO head, and captures the result in an output register presented on a valid/ready stream.

Parameters:
- DATA_WIDTH, 8, width of data word; any value >= 2.
- SHIFT_WIDTH, clog2(DATA_WIDTH) (DATA_WIDTH a power of 2) else clog2(DATA_WIDTH)+1, width of shift amount; same rule as barrel_shifter.
- DEPTH, 4, request FIFO entries; power of 2, >= 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_data  input  DATA_WIDTH  word to rotate.
- in_shift  input  SHIFT_WIDTH  raw rotate amount.
- in_dir  input  1  0 = rotate left, 1 = rotate right.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready.
- out_data  output  DATA_WIDTH  rotated word.
- out_err  output  1  raw shift was >= DATA_WIDTH (see Optional Feature).
- fifo_count  output  clog2(DEPTH)+1  occupied FIFO entries (excludes output register).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: out_valid=0, out_data=0, out_err=0, fifo_count=0, FIFO pointers=0. in_ready=0 while rst=1.
- Reset mid-operation: all buffered requests and any held result are discarded; nothing is emitted afterwards.
- Storage:
  - Circular FIFO of DEPTH entries, each holding {data, eff_shift, err}; read/write pointers wrap at DEPTH.
  - Output register holds one result.
  - Total in-flight capacity = DEPTH+1.
- Input side:
  - in_ready = !rst && (fifo_count != DEPTH).
  - No push-while-full bypass: when full, in_ready stays 0 even if a pop occurs in the same cycle.
- Shift reduction, computed at push:
  - s_mod = in_shift mod DATA_WIDTH.
  - Left: eff_shift = s_mod.
  - Right: eff_shift = (DATA_WIDTH - s_mod) mod DATA_WIDTH; s_mod=0 gives eff_shift=0.
  - err = (in_shift >= DATA_WIDTH).
  - For power-of-2 DATA_WIDTH, the reduction is a no-op and err is never set.
- Rotator: one barrel_shifter instance; data_in = head.data, shift_val_in = head.eff_shift. Its output is the next out_data.
- Output side:
  - The output register loads the rotator result (and head.err) and pops the FIFO when fifo_count != 0 && (!out_valid || out_ready).
  - out_valid clears when consumed with the FIFO empty.
  - out_data/out_err hold stable while out_valid && !out_ready.
- Latency: request accepted at edge N into an empty block → out_valid=1 after edge N+1. Throughput is 1 result/cycle when out_ready is held high.
- Simultaneous push and pop, not full: both occur, fifo_count unchanged. Push and load in one cycle with fifo_count=0 is not allowed; the new entry waits one cycle.
- fifo_count: +1 on push only, -1 on pop only, unchanged on both.
- Ordering: strict FIFO; no reordering or dropping.

Optional Feature:
- Macro: ROT_RANGE_CHECK_EN.
- Defined:
  - err is computed as above and carried with the entry to out_err, aligned with out_valid.
  - A simulation assertion fires if out_err=1 while out_valid=0.
- Undefined:
  - err logic and FIFO err bits are not built; out_err is tied 0.
  - Shift reduction is unchanged, so out-of-range shifts are still wrapped silently.

Test Plan:
- Rotate left, DATA_WIDTH=8: push 0x99, shift 3, dir 0, out_ready=1 → out_data=0xCC two cycles after acceptance; out_err=0.
- Rotate right, DATA_WIDTH=8: 0x99, shift 3, dir 1 → out_data=0x33. Then 0xA5, shift 0, dir 1 → 0xA5.
- Reduction, DATA_WIDTH=6, SHIFT_WIDTH=3: 6'b100001, shift 7, dir 0 → 6'b000011, out_err=1 with macro, 0 without. Shift 6, dir 1 → data unchanged.
- Backpressure/full, DEPTH=4: out_ready=0, push 0x01..0x05 → in_ready=0 after 5th accept, fifo_count=4, out_data=0x01 stable. Raise out_ready → outputs in order 0x01..0x05 on consecutive cycles; in_ready returns 1 the cycle after the first pop.
- Streaming: in_valid and out_ready held 1 for 16 pushes with random shifts → 16 results in order, no bubbles after the first, fifo_count never exceeds 1.
- Reset mid-operation: 3 entries buffered plus a held result, assert rst one cycle → out_valid=0, fifo_count=0, in_ready=0 during reset. Afterwards the next push 0x80 shift 1 left → out_data=0x01, and no stale data appears.
